// File: rtl/gpu_cmd_queue_if.sv
// Push-side command interface of gpu_cmd_queue: valid/ready handshake plus every command field.
// The master drives commands; the slave (the queue) answers with in_ready.
interface gpu_cmd_queue_if #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240
);
    localparam int WW = $clog2(FB_WIDTH) + 2;
    localparam int HW = $clog2(FB_HEIGHT) + 2;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_opcode;
    logic [31:0]   in_address;
    logic [15:0]   in_address_x;
    logic [15:0]   in_address_y;
    logic [15:0]   in_image_width;
    logic [WW-1:0] in_width;
    logic [WW-1:0] in_x;
    logic [HW-1:0] in_height;
    logic [HW-1:0] in_y;
    logic [15:0]   in_clear_color;

    modport master (
        output in_valid, in_opcode, in_address, in_address_x, in_address_y,
               in_image_width, in_width, in_x, in_height, in_y, in_clear_color,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_address, in_address_x, in_address_y,
               in_image_width, in_width, in_x, in_height, in_y, in_clear_color,
        output in_ready
    );
endinterface

// File: rtl/gpu_cmd_queue.sv
// Command FIFO in front of the GPU draw/clear engine; replays DRAW/CLEAR as field-stable single-cycle strobes.
// Optional macro GPU_CMDQ_FENCE_EN adds the vsync port and makes opcode 2 wait for a vsync rising edge.
module gpu_cmd_queue #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    gpu_cmd_queue_if.slave            push,
    output logic [31:0]               ctrl_address,
    output logic [15:0]               ctrl_address_x,
    output logic [15:0]               ctrl_address_y,
    output logic [15:0]               ctrl_image_width,
    output logic [$clog2(FB_WIDTH)+1:0]  ctrl_width,
    output logic [$clog2(FB_WIDTH)+1:0]  ctrl_x,
    output logic [$clog2(FB_HEIGHT)+1:0] ctrl_height,
    output logic [$clog2(FB_HEIGHT)+1:0] ctrl_y,
    output logic [15:0]               ctrl_clear_color,
    output logic                      ctrl_draw,
    output logic                      ctrl_clear,
    input  logic                      gpu_busy,
`ifdef GPU_CMDQ_FENCE_EN
    input  logic                      vsync,
`endif
    output logic [$clog2(DEPTH):0]    count,
    output logic                      idle
);
    localparam int WW = $clog2(FB_WIDTH) + 2;
    localparam int HW = $clog2(FB_HEIGHT) + 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]    opcode;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [WW-1:0] width;
        logic [WW-1:0] x;
        logic [HW-1:0] height;
        logic [HW-1:0] y;
        logic [15:0]   clear_color;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_FIRE      = 3'd2,
        S_SETTLE    = 3'd3,
        S_WAIT_DONE = 3'd4
`ifdef GPU_CMDQ_FENCE_EN
        ,
        S_FENCE     = 3'd5
`endif
    } state_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    state_t          r_state;
    logic [1:0]      r_op;
    logic [31:0]     r_address;
    logic [15:0]     r_address_x;
    logic [15:0]     r_address_y;
    logic [15:0]     r_image_width;
    logic [WW-1:0]   r_width;
    logic [WW-1:0]   r_x;
    logic [HW-1:0]   r_height;
    logic [HW-1:0]   r_y;
    logic [15:0]     r_clear_color;
    logic            r_draw;
    logic            r_clear;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    entry_t          w_in_entry;
    entry_t          w_head;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == {CW{1'b0}});
    assign w_push  = push.in_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !gpu_busy;
    assign w_head  = r_mem[r_rd_ptr];

    assign w_in_entry = '{
        opcode:      push.in_opcode,
        address:     push.in_address,
        address_x:   push.in_address_x,
        address_y:   push.in_address_y,
        image_width: push.in_image_width,
        width:       push.in_width,
        x:           push.in_x,
        height:      push.in_height,
        y:           push.in_y,
        clear_color: push.in_clear_color
    };

    // Entry storage; contents are meaningless outside the count window so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GPU_CMDQ_FENCE_EN
    logic r_vsync_d;

    // Previous-cycle vsync for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
        end
    end
`endif

    // Issue FSM: fields load on pop, strobe is raised one cycle after SETUP so fields lead it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= 2'd0;
            r_address     <= 32'd0;
            r_address_x   <= 16'd0;
            r_address_y   <= 16'd0;
            r_image_width <= 16'd0;
            r_width       <= {WW{1'b0}};
            r_x           <= {WW{1'b0}};
            r_height      <= {HW{1'b0}};
            r_y           <= {HW{1'b0}};
            r_clear_color <= 16'd0;
            r_draw        <= 1'b0;
            r_clear       <= 1'b0;
        end else begin
            r_draw  <= 1'b0;
            r_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op          <= w_head.opcode;
                        r_address     <= w_head.address;
                        r_address_x   <= w_head.address_x;
                        r_address_y   <= w_head.address_y;
                        r_image_width <= w_head.image_width;
                        r_width       <= w_head.width;
                        r_x           <= w_head.x;
                        r_height      <= w_head.height;
                        r_y           <= w_head.y;
                        r_clear_color <= w_head.clear_color;
                        case (w_head.opcode)
                            2'd0, 2'd1: r_state <= S_SETUP;
`ifdef GPU_CMDQ_FENCE_EN
                            2'd2:       r_state <= S_FENCE;
`endif
                            default:    r_state <= S_IDLE;
                        endcase
                    end
                end
                S_SETUP: begin
                    r_draw  <= (r_op == 2'd0);
                    r_clear <= (r_op == 2'd1);
                    r_state <= S_FIRE;
                end
                S_FIRE:   r_state <= S_SETTLE;
                S_SETTLE: r_state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    // A GPU that never raises busy simply lets us fall through here.
                    if (!gpu_busy) begin
                        r_state <= S_IDLE;
                    end
                end
`ifdef GPU_CMDQ_FENCE_EN
                S_FENCE: begin
                    if (vsync && !r_vsync_d) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign push.in_ready    = !w_full;
    assign count            = r_count;
    assign idle             = (r_state == S_IDLE) && w_empty;
    assign ctrl_address     = r_address;
    assign ctrl_address_x   = r_address_x;
    assign ctrl_address_y   = r_address_y;
    assign ctrl_image_width = r_image_width;
    assign ctrl_width       = r_width;
    assign ctrl_x           = r_x;
    assign ctrl_height      = r_height;
    assign ctrl_y           = r_y;
    assign ctrl_clear_color = r_clear_color;
    assign ctrl_draw        = r_draw;
    assign ctrl_clear       = r_clear;
endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Self-checking bench for gpu_cmd_queue: table of single commands, then busy, full, reset, drop and fence sequences.
// A negedge monitor compares every strobe's fields against a queue of expected commands.
module tb_gpu_cmd_queue;
    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;
    localparam int DEPTH     = 8;
    localparam int WW = $clog2(FB_WIDTH) + 2;
    localparam int HW = $clog2(FB_HEIGHT) + 2;

    typedef struct packed {
        logic [31:0]   addr;
        logic [15:0]   ax;
        logic [15:0]   ay;
        logic [15:0]   iw;
        logic [WW-1:0] w;
        logic [WW-1:0] x;
        logic [HW-1:0] h;
        logic [HW-1:0] y;
        logic [15:0]   color;
    } fields_t;

    typedef struct packed {
        logic [1:0] op;
        fields_t    f;
    } cmd_t;

    typedef struct {
        cmd_t cmd;
        logic exp_draw;
        logic exp_clear;
        int   lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic gpu_busy;
`ifdef GPU_CMDQ_FENCE_EN
    logic vsync;
`endif
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
    logic [WW-1:0] ctrl_width, ctrl_x;
    logic [HW-1:0] ctrl_height, ctrl_y;
    logic          ctrl_draw, ctrl_clear;
    logic [$clog2(DEPTH):0] count;
    logic          idle;
    fields_t       act_f;

    gpu_cmd_queue_if #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) cif ();

    gpu_cmd_queue #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .push(cif.slave),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
        .ctrl_width(ctrl_width), .ctrl_x(ctrl_x), .ctrl_height(ctrl_height), .ctrl_y(ctrl_y),
        .ctrl_clear_color(ctrl_clear_color), .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear),
        .gpu_busy(gpu_busy),
`ifdef GPU_CMDQ_FENCE_EN
        .vsync(vsync),
`endif
        .count(count), .idle(idle)
    );

    assign act_f = {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                    ctrl_width, ctrl_x, ctrl_height, ctrl_y, ctrl_clear_color};

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_strobes = 0;
    int   draw_cyc[$];
    int   clear_cyc[$];
    cmd_t exp_q[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] op, input logic [31:0] a,
                                input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] iw,
                                input logic [WW-1:0] w, input logic [WW-1:0] x,
                                input logic [HW-1:0] h, input logic [HW-1:0] y, input logic [15:0] col);
        cmd_t c;
        c.op = op;
        c.f  = '{addr: a, ax: ax, ay: ay, iw: iw, w: w, x: x, h: h, y: y, color: col};
        return c;
    endfunction

    // One clock; outputs sampled 1 time unit after the edge, strobe cycles logged.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ctrl_draw)  draw_cyc.push_back(cyc);
        if (ctrl_clear) clear_cyc.push_back(cyc);
    endtask

    // Present a command for one cycle; sb says whether the bench expects it to be issued.
    task automatic send(input cmd_t c, input bit sb);
        cif.in_valid       = 1'b1;
        cif.in_opcode      = c.op;
        cif.in_address     = c.f.addr;
        cif.in_address_x   = c.f.ax;
        cif.in_address_y   = c.f.ay;
        cif.in_image_width = c.f.iw;
        cif.in_width       = c.f.w;
        cif.in_x           = c.f.x;
        cif.in_height      = c.f.h;
        cif.in_y           = c.f.y;
        cif.in_clear_color = c.f.color;
        if (sb) exp_q.push_back(c);
        step();
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expected command.
    always @(negedge clk) begin
        if (ctrl_draw || ctrl_clear) begin
            cmd_t e;
            n_strobes++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: strobe draw=%0b clear=%0b, expected none", ctrl_draw, ctrl_clear);
            end else begin
                e = exp_q.pop_front();
                check("sb_strobe_kind", {ctrl_draw, ctrl_clear}, {e.op == 2'd0, e.op == 2'd1});
                check("sb_fields", act_f, e.f);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    vec_t  vecs[5];
    int    n_vec;
    int    t0, s, b, n0, stable_err, act_lat;
    cmd_t  c_clr, c_drw, c_a, c_b;
    logic [DEPTH+1:0] ready_v, exp_rv;

    initial begin
        reset = 1'b1;
        gpu_busy = 1'b0;
`ifdef GPU_CMDQ_FENCE_EN
        vsync = 1'b0;
`endif
        cif.in_valid = 1'b0;
        cif.in_opcode = 2'd0; cif.in_address = 32'd0; cif.in_address_x = 16'd0;
        cif.in_address_y = 16'd0; cif.in_image_width = 16'd0; cif.in_width = '0;
        cif.in_x = '0; cif.in_height = '0; cif.in_y = '0; cif.in_clear_color = 16'd0;
        step(); step();
        check("rst_ready", cif.in_ready, 1'b1);
        check("rst_count", count, 0);
        check("rst_idle", idle, 1'b1);
        check("rst_strobes", {ctrl_draw, ctrl_clear}, 2'b00);
        check("rst_fields", act_f, 0);
        reset = 1'b0;
        step();

        // Single commands, each from an empty queue with the GPU idle.
        vecs[0] = '{cmd: mk(2'd0, 32'h0000_1000, 16'd0, 16'd0, 16'd64, 11'd16, 11'd10, 10'd8, 10'd20, 16'd0),
                    exp_draw: 1'b1, exp_clear: 1'b0, lat: 3};
        vecs[1] = '{cmd: mk(2'd1, 32'hCAFE_0000, 16'd5, 16'd6, 16'd7, 11'd33, 11'd44, 10'd55, 10'd66, 16'hF801),
                    exp_draw: 1'b0, exp_clear: 1'b1, lat: 3};
        vecs[2] = '{cmd: mk(2'd0, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 11'h7FF, 11'd399, 10'h3FF, 10'd239, 16'hFFFF),
                    exp_draw: 1'b1, exp_clear: 1'b0, lat: 3};
        vecs[3] = '{cmd: mk(2'd3, 32'h1234_5678, 16'd1, 16'd2, 16'd3, 11'd4, 11'd5, 10'd6, 10'd7, 16'd8),
                    exp_draw: 1'b0, exp_clear: 1'b0, lat: -1};
        n_vec = 4;
`ifndef GPU_CMDQ_FENCE_EN
        vecs[4] = '{cmd: mk(2'd2, 32'h0000_0BAD, 16'd9, 16'd9, 16'd9, 11'd9, 11'd9, 10'd9, 10'd9, 16'd9),
                    exp_draw: 1'b0, exp_clear: 1'b0, lat: -1};
        n_vec = 5;
`endif
        for (int i = 0; i < n_vec; i++) begin
            draw_cyc.delete();
            clear_cyc.delete();
            t0 = cyc;
            send(vecs[i].cmd, vecs[i].lat >= 0);
            cif.in_valid = 1'b0;
            check($sformatf("vec%0d_count_after_push", i), count, 1);
            step();
            if (vecs[i].lat >= 0) check($sformatf("vec%0d_fields_before_strobe", i), act_f, vecs[i].cmd.f);
            repeat (6) step();
            act_lat = (draw_cyc.size() == 0) ? -1 : ((draw_cyc.size() > 1) ? -2 : draw_cyc[0] - t0);
            check($sformatf("vec%0d_draw_cycle", i), act_lat, vecs[i].exp_draw ? vecs[i].lat : -1);
            act_lat = (clear_cyc.size() == 0) ? -1 : ((clear_cyc.size() > 1) ? -2 : clear_cyc[0] - t0);
            check($sformatf("vec%0d_clear_cycle", i), act_lat, vecs[i].exp_clear ? vecs[i].lat : -1);
            check($sformatf("vec%0d_idle_after", i), {idle, count}, {1'b1, 4'd0});
        end

        // CLEAR then DRAW with the GPU busy for 50 cycles after the first strobe.
        draw_cyc.delete();
        clear_cyc.delete();
        c_clr = mk(2'd1, 32'hAAAA_0000, 16'd11, 16'd12, 16'd13, 11'd14, 11'd15, 10'd16, 10'd17, 16'hF801);
        c_drw = mk(2'd0, 32'hBBBB_0000, 16'd21, 16'd22, 16'd23, 11'd24, 11'd25, 10'd26, 10'd27, 16'd0);
        t0 = cyc;
        send(c_clr, 1'b1);
        send(c_drw, 1'b1);
        cif.in_valid = 1'b0;
        step();
        check("busy_first_clear_cycle", (clear_cyc.size() > 0) ? clear_cyc[0] - t0 : -1, 3);
        gpu_busy = 1'b1;
        stable_err = 0;
        repeat (50) begin
            step();
            if (act_f !== c_clr.f || ctrl_draw || ctrl_clear) stable_err++;
        end
        check("busy_fields_held", stable_err, 0);
        check("busy_count_held", count, 1);
        gpu_busy = 1'b0;
        b = cyc;
        repeat (6) step();
        check("busy_second_draw_after_release", (draw_cyc.size() == 1) ? draw_cyc[0] - b : -1, 3);
        repeat (3) step();
        check("busy_idle_after", idle, 1'b1);

        // Overfill with the GPU busy: DEPTH accepted, two refused, order preserved on drain.
        draw_cyc.delete();
        clear_cyc.delete();
        gpu_busy = 1'b1;
        exp_rv = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) exp_rv[i] = 1'b1;
            ready_v[i] = cif.in_ready;
            send(mk(2'(i % 2), 32'h2000 + 32'(i * 16), 16'(i), 16'(i + 1), 16'(i + 2),
                    11'(i + 3), 11'(i + 4), 10'(i + 5), 10'(i + 6), 16'(i + 7)), i < DEPTH);
        end
        cif.in_valid = 1'b0;
        check("full_ready_pattern", ready_v, exp_rv);
        check("full_count", count, DEPTH);
        check("full_no_issue_while_busy", draw_cyc.size() + clear_cyc.size(), 0);
        n0 = n_strobes;
        gpu_busy = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (idle && exp_q.size() == 0) break;
        end
        check("drain_strobe_count", n_strobes - n0, DEPTH);
        check("drain_scoreboard_empty", exp_q.size(), 0);
        check("drain_idle", idle, 1'b1);

        // Reset while in WAIT_DONE with three commands still queued.
        draw_cyc.delete();
        t0 = cyc;
        send(mk(2'd0, 32'h3000, 16'd1, 16'd1, 16'd1, 11'd1, 11'd1, 10'd1, 10'd1, 16'd1), 1'b1);
        send(mk(2'd0, 32'h3010, 16'd2, 16'd2, 16'd2, 11'd2, 11'd2, 10'd2, 10'd2, 16'd2), 1'b0);
        send(mk(2'd1, 32'h3020, 16'd3, 16'd3, 16'd3, 11'd3, 11'd3, 10'd3, 10'd3, 16'd3), 1'b0);
        send(mk(2'd0, 32'h3030, 16'd4, 16'd4, 16'd4, 11'd4, 11'd4, 10'd4, 10'd4, 16'd4), 1'b0);
        cif.in_valid = 1'b0;
        gpu_busy = 1'b1;
        step(); step();
        check("rstmid_draw_before", (draw_cyc.size() == 1) ? draw_cyc[0] - t0 : -1, 3);
        check("rstmid_count_before", count, 3);
        reset = 1'b1;
        step();
        check("rstmid_count", count, 0);
        check("rstmid_strobes", {ctrl_draw, ctrl_clear}, 2'b00);
        check("rstmid_fields", act_f, 0);
        check("rstmid_idle", idle, 1'b1);
        reset = 1'b0;
        gpu_busy = 1'b0;
        n0 = n_strobes;
        repeat (20) step();
        check("rstmid_no_strobe_after", n_strobes - n0, 0);

        // Opcode 3 ahead of a CLEAR costs exactly one extra cycle.
        draw_cyc.delete();
        clear_cyc.delete();
        t0 = cyc;
        send(mk(2'd3, 32'h4000, 16'd0, 16'd0, 16'd0, 11'd0, 11'd0, 10'd0, 10'd0, 16'd0), 1'b0);
        send(mk(2'd1, 32'h4100, 16'd1, 16'd2, 16'd3, 11'd4, 11'd5, 10'd6, 10'd7, 16'h07E0), 1'b1);
        cif.in_valid = 1'b0;
        repeat (8) step();
        check("op3_clear_cycle", (clear_cyc.size() == 1) ? clear_cyc[0] - t0 : -1, 4);
        check("op3_no_draw", draw_cyc.size(), 0);

        // DRAW, FENCE, DRAW.
        draw_cyc.delete();
        c_a = mk(2'd0, 32'h5000, 16'd1, 16'd1, 16'd1, 11'd8, 11'd8, 10'd8, 10'd8, 16'd0);
        c_b = mk(2'd0, 32'h5100, 16'd2, 16'd2, 16'd2, 11'd9, 11'd9, 10'd9, 10'd9, 16'd0);
        t0 = cyc;
        send(c_a, 1'b1);
        send(mk(2'd2, 32'h0, 16'd0, 16'd0, 16'd0, 11'd0, 11'd0, 10'd0, 10'd0, 16'd0), 1'b0);
        send(c_b, 1'b1);
        cif.in_valid = 1'b0;
`ifdef GPU_CMDQ_FENCE_EN
        repeat (9) step();
        check("fence_holds_second_draw", draw_cyc.size(), 1);
        vsync = 1'b1;
        b = cyc;
        step();
        vsync = 1'b0;
        repeat (5) step();
        check("fence_second_draw_after_vsync", (draw_cyc.size() == 2) ? draw_cyc[1] - b : -1, 3);
`else
        repeat (9) step();
        check("fence_off_second_draw", (draw_cyc.size() == 2) ? draw_cyc[1] - t0 : -1, 9);
`endif
        check("fence_first_draw", (draw_cyc.size() > 0) ? draw_cyc[0] - t0 : -1, 3);
        repeat (4) step();
        check("final_idle", {idle, count}, {1'b1, 4'd0});
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
